// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code consumer: pops bytes from the keyboard FIFO,
// tracks the held key, its ASCII value and a BCD press counter.
//   in : clk, clrn (async, active-low), data[7:0], ready, overflow
//   out: nextdata_n, key_code[7:0], key_ascii[7:0], key_down,
//        extended, press_cnt[7:0] (packed BCD), ovf_sticky
module ps2_key_decoder (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_down,
  output logic       extended,
  output logic [7:0] press_cnt,
  output logic       ovf_sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PROC = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_q;
  logic       brk_p, ext_p;
  logic       is_e0, is_f0, same_key;

  function automatic logic [7:0] to_ascii(input logic [7:0] c);
    logic [7:0] a;
    a = 8'h00;
    case (c)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62;
      8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66;
      8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A;
      8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E;
      8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72;
      8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76;
      8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31;
      8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35;
      8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo, hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  assign is_e0    = (byte_q == 8'hE0);
  assign is_f0    = (byte_q == 8'hF0);
  assign same_key = (byte_q == key_code) && (ext_p == extended);

  // ready is only looked at in IDLE; the FIFO flag lags the pop by a cycle
  always_comb begin
    state_d    = state_q;
    nextdata_n = 1'b1;
    unique case (state_q)
      IDLE: if (ready) state_d = POP;
      POP: begin
        nextdata_n = 1'b0;
        state_d    = PROC;
      end
      PROC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ready) byte_q <= data;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ovf_sticky <= 1'b0;
    end else if (overflow) begin
      ovf_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      brk_p     <= 1'b0;
      ext_p     <= 1'b0;
      key_code  <= 8'h00;
      key_ascii <= 8'h00;
      key_down  <= 1'b0;
      extended  <= 1'b0;
      press_cnt <= 8'h00;
    end else if (state_q == PROC) begin
      if (is_e0) begin
        ext_p <= 1'b1;
      end else if (is_f0) begin
        brk_p <= 1'b1;
      end else begin
        brk_p <= 1'b0;
        ext_p <= 1'b0;
        if (brk_p) begin
          if (same_key) key_down <= 1'b0;
        end else if (!(key_down && same_key)) begin
          // a held key resent unchanged is typematic repeat, not a press
          key_code  <= byte_q;
          extended  <= ext_p;
          key_down  <= 1'b1;
          press_cnt <= bcd_inc(press_cnt);
          key_ascii <= ext_p ? 8'h00 : to_ascii(byte_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a queue-based FIFO model.
// Prints one summary line: CHECKS n ERRORS m.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic       nextdata_n;
  logic [7:0] key_code, key_ascii, press_cnt;
  logic       key_down, extended, ovf_sticky;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic prev_low = 1'b0;
  logic [7:0] fifo [$];

  ps2_key_decoder dut (
    .clk       (clk),
    .clrn      (clrn),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .nextdata_n(nextdata_n),
    .key_code  (key_code),
    .key_ascii (key_ascii),
    .key_down  (key_down),
    .extended  (extended),
    .press_cnt (press_cnt),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  // keyboard FIFO model: pops on a low strobe, updates ready/data
  always @(negedge clk) begin
    logic [7:0] tmp;
    if (clrn && !nextdata_n) begin
      if (prev_low) begin
        errors++;
        $display("FAIL pop_twice: nextdata_n low two cycles");
      end
      if (fifo.size() == 0) begin
        errors++;
        $display("FAIL pop_empty: pop with empty fifo");
      end else begin
        tmp = fifo.pop_front();
        pops++;
      end
    end
    prev_low = clrn && !nextdata_n;
    ready = (fifo.size() != 0);
    data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (fifo.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: fifo %0d expected 0", fifo.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  typedef struct {
    logic [23:0] b;
    int          nb;
    logic [7:0]  code;
    logic [7:0]  ascii;
    logic        down;
    logic        ext;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int base;
    int lows;
    bit hit;
    logic [7:0] exp_cnt;

    vecs[0]  = '{24'h1C0000, 1, 8'h1C, 8'h61, 1'b1, 1'b0, 8'h01};
    vecs[1]  = '{24'h1C0000, 1, 8'h1C, 8'h61, 1'b1, 1'b0, 8'h01};
    vecs[2]  = '{24'hF01C00, 2, 8'h1C, 8'h61, 1'b0, 1'b0, 8'h01};
    vecs[3]  = '{24'hE07500, 2, 8'h75, 8'h00, 1'b1, 1'b1, 8'h02};
    vecs[4]  = '{24'hF07500, 2, 8'h75, 8'h00, 1'b1, 1'b1, 8'h02};
    vecs[5]  = '{24'hE0F075, 3, 8'h75, 8'h00, 1'b0, 1'b1, 8'h02};
    vecs[6]  = '{24'h290000, 1, 8'h29, 8'h20, 1'b1, 1'b0, 8'h03};
    vecs[7]  = '{24'hF02900, 2, 8'h29, 8'h20, 1'b0, 1'b0, 8'h03};
    vecs[8]  = '{24'h290000, 1, 8'h29, 8'h20, 1'b1, 1'b0, 8'h04};
    vecs[9]  = '{24'h5A0000, 1, 8'h5A, 8'h0D, 1'b1, 1'b0, 8'h05};
    vecs[10] = '{24'hE01C00, 2, 8'h1C, 8'h00, 1'b1, 1'b1, 8'h06};
    vecs[11] = '{24'h1C0000, 1, 8'h1C, 8'h61, 1'b1, 1'b0, 8'h07};
    vecs[12] = '{24'h450000, 1, 8'h45, 8'h30, 1'b1, 1'b0, 8'h08};
    vecs[13] = '{24'h0E0000, 1, 8'h0E, 8'h00, 1'b1, 1'b0, 8'h09};
    vecs[14] = '{24'h1A0000, 1, 8'h1A, 8'h7A, 1'b1, 1'b0, 8'h10};

    // reset values, idle with empty FIFO
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    @(negedge clk);
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_key_ascii", key_ascii, 8'h00);
    chk("rst_key_down", key_down, 0);
    chk("rst_extended", extended, 0);
    chk("rst_press_cnt", press_cnt, 8'h00);
    chk("rst_ovf_sticky", ovf_sticky, 0);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!nextdata_n) lows++;
    end
    chk("idle_no_pop", lows, 0);

    // first byte: pop timing and two-cycle output latency
    base = pops;
    @(posedge clk);
    #1 push(8'h1C);
    @(negedge clk);
    @(negedge clk);
    chk("pop_low", nextdata_n, 0);
    @(negedge clk);
    chk("pop_one_cycle", nextdata_n, 1);
    chk("not_yet_code", key_code, 8'h00);
    @(negedge clk);
    chk("t2_code", key_code, 8'h1C);
    chk("t2_ascii", key_ascii, 8'h61);
    chk("t2_down", key_down, 1);
    chk("t2_cnt", press_cnt, 8'h01);

    // table-driven sequences (cumulative state)
    for (int v = 0; v < 15; v++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < vecs[v].nb; k++) begin
        logic [23:0] w;
        w = vecs[v].b << (8 * k);
        push(w[23:16]);
      end
      drain();
      chk($sformatf("v%0d_code", v), key_code, vecs[v].code);
      chk($sformatf("v%0d_ascii", v), key_ascii, vecs[v].ascii);
      chk($sformatf("v%0d_down", v), key_down, vecs[v].down);
      chk($sformatf("v%0d_ext", v), extended, vecs[v].ext);
      chk($sformatf("v%0d_cnt", v), press_cnt, vecs[v].cnt);
      if (v == 2) chk("five_pops", pops - base, 5);
    end

    // BCD rollover over 100 presses
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      logic [7:0] k;
      k = (i % 2) ? 8'h16 : 8'h1E;
      @(posedge clk);
      #1;
      push(k);
      push(8'hF0);
      push(k);
      drain();
      exp_cnt = {4'((i % 100) / 10), 4'(i % 10)};
      chk($sformatf("bcd_%0d", i), press_cnt, exp_cnt);
    end

    // overflow sticky
    chk("ovf_before", ovf_sticky, 0);
    @(posedge clk);
    #1 overflow = 1'b1;
    @(posedge clk);
    #1 overflow = 1'b0;
    @(negedge clk);
    chk("ovf_set", ovf_sticky, 1);
    @(posedge clk);
    #1 push(8'h24);
    drain();
    chk("ovf_held", ovf_sticky, 1);
    chk("ovf_traffic_code", key_code, 8'h24);

    // reset in POP drops the byte
    @(posedge clk);
    #1 push(8'h2B);
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!nextdata_n) begin
        hit = 1;
        break;
      end
    end
    chk("pop_seen", hit, 1);
    #1 clrn = 1'b0;
    #1;
    chk("rst_in_pop_n", nextdata_n, 1);
    chk("ovf_cleared", ovf_sticky, 0);
    chk("rst_cnt", press_cnt, 8'h00);
    base = pops;
    @(posedge clk);
    #1 clrn = 1'b1;
    repeat (10) @(negedge clk);
    chk("dropped_code", key_code, 8'h00);
    chk("dropped_down", key_down, 0);
    chk("no_extra_pop", pops - base, 0);
    chk("ovf_stays_clear", ovf_sticky, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
